// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, branch condition codes and stage entry type for the branch unit
package rv_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_EQ  = 3'd0;
  localparam logic [2:0] F3_NE  = 3'd1;
  localparam logic [2:0] F3_LT  = 3'd4;
  localparam logic [2:0] F3_GE  = 3'd5;
  localparam logic [2:0] F3_LTU = 3'd6;
  localparam logic [2:0] F3_GEU = 3'd7;
  typedef struct packed {
    logic valid;
    logic taken;
    logic trap;
  } bru_entry_t;
  function automatic int tid_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rv_bru_if.sv
// rv_bru_if: request and result bus of the branch resolution unit
interface rv_bru_if #(parameter int XLEN = 32, parameter int NTHREADS = 4);
  localparam int TW = rv_pkg::tid_w(NTHREADS);
  logic in_valid;
  logic in_ready;
  logic [TW-1:0] in_tid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] trap_vec;
  logic [NTHREADS-1:0] flush;
  logic out_valid;
  logic out_ready;
  logic [TW-1:0] out_tid;
  logic out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic out_trap;
  modport slave (
    input in_valid, in_tid, opcode, funct3, pc, rs1, rs2, imm, trap_vec, flush, out_ready,
    output in_ready, out_valid, out_tid, out_taken, out_target, out_link, out_trap
  );
  modport master (
    output in_valid, in_tid, opcode, funct3, pc, rs1, rs2, imm, trap_vec, flush, out_ready,
    input in_ready, out_valid, out_tid, out_taken, out_target, out_link, out_trap
  );
endinterface

// File: rtl/rv_bru_cond.sv
// rv_bru_cond: combinational branch condition evaluator
module rv_bru_cond import rv_pkg::*; #(parameter int XLEN = 32) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);
  logic eq, lt, ltu;
  assign eq  = rs1 == rs2;
  assign lt  = $signed(rs1) < $signed(rs2);
  assign ltu = rs1 < rs2;
  assign taken = funct3 == F3_EQ  ? eq   :
                 funct3 == F3_NE  ? !eq  :
                 funct3 == F3_LT  ? lt   :
                 funct3 == F3_GE  ? !lt  :
                 funct3 == F3_LTU ? ltu  :
                 funct3 == F3_GEU ? !ltu : 1'b0;
endmodule

// File: rtl/rv_bru.sv
// rv_bru: two-stage branch resolution unit with per-thread flush and ready/valid flow control
module rv_bru import rv_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int NTHREADS    = 4,
  parameter int SKIP_STAGE1 = 0
) (
  input logic     clk,
  input logic     rst_n,
  rv_bru_if.slave bus
);
  localparam int TW = tid_w(NTHREADS);
  bru_entry_t c_e, e1, e2;
  logic [TW-1:0] t1, t2;
  logic [XLEN-1:0] pc_imm, rs1_imm, link, c_tgt, tgt1, link1, tv1, n_tgt, tgt2, link2;
  logic cond, s2_free, ready, n_trap;
  rv_bru_cond #(.XLEN(XLEN)) u_cond (
    .funct3(bus.funct3),
    .rs1(bus.rs1),
    .rs2(bus.rs2),
    .taken(cond)
  );
  always_comb begin
    pc_imm = bus.pc + bus.imm;
    rs1_imm = bus.rs1 + bus.imm;
    link = bus.pc + XLEN'(4);
    c_e.valid = bus.in_valid && !bus.flush[bus.in_tid];
    c_e.trap = bus.opcode == OP_SYSTEM;
    c_e.taken = bus.opcode == OP_JAL || bus.opcode == OP_JALR || c_e.trap ||
                (bus.opcode == OP_BRANCH && cond);
    c_tgt = bus.opcode == OP_JALR ? rs1_imm & ~XLEN'(1) : c_e.taken ? pc_imm : link;
  end
  // Misalignment is resolved after stage 1 so the adder result is already registered
  assign n_trap = e1.trap || (e1.taken && tgt1[1]);
  assign n_tgt = n_trap ? tv1 : tgt1;
  assign s2_free = !e2.valid || bus.out_ready;
  if (SKIP_STAGE1 != 0) begin : g_skip
    assign e1 = c_e;
    assign t1 = bus.in_tid;
    assign tgt1 = c_tgt;
    assign link1 = link;
    assign tv1 = bus.trap_vec;
    assign ready = s2_free;
  end else begin : g_s1
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        e1 <= '0;
        t1 <= '0;
        tgt1 <= '0;
        link1 <= '0;
        tv1 <= '0;
      end else if (ready) begin
        e1 <= c_e;
        t1 <= bus.in_tid;
        tgt1 <= c_tgt;
        link1 <= link;
        tv1 <= bus.trap_vec;
      end else if (bus.flush[t1]) e1.valid <= 1'b0;
    assign ready = !e1.valid || s2_free;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e2 <= '0;
      t2 <= '0;
      tgt2 <= '0;
      link2 <= '0;
    end else if (s2_free) begin
      e2 <= '{valid: e1.valid && !bus.flush[t1], taken: e1.taken, trap: n_trap};
      t2 <= t1;
      tgt2 <= n_tgt;
      link2 <= link1;
    end else if (bus.flush[t2]) e2.valid <= 1'b0;
  assign bus.in_ready = ready;
  assign bus.out_valid = e2.valid;
  assign bus.out_tid = t2;
  assign bus.out_taken = e2.taken;
  assign bus.out_trap = e2.trap;
  assign bus.out_target = tgt2;
  assign bus.out_link = link2;
endmodule

// File: tb/tb_rv_bru.sv
// tb_rv_bru: scoreboard bench for rv_bru covering decode, backpressure, flush and reset
module tb_rv_bru;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  rv_bru_if #(.XLEN(32), .NTHREADS(4)) bus();
  rv_bru #(.XLEN(32), .NTHREADS(4), .SKIP_STAGE1(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [1:0]  tid;
    logic        taken;
    logic        trap;
    logic [31:0] tgt;
    logic [31:0] link;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;
  logic saw_stall = 0;
  logic pv = 0;
  logic pr = 0;
  logic [31:0] ptgt = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] tid,
                                 input logic [31:0] pc, rs1, rs2, imm, tv);
    exp_t e;
    e.tid = tid;
    e.trap = 0;
    e.taken = 0;
    e.link = pc + 32'd4;
    e.tgt = pc + 32'd4;
    case (op)
      7'h6f: begin e.taken = 1; e.tgt = pc + imm; end
      7'h67: begin e.taken = 1; e.tgt = (rs1 + imm) & 32'hffff_fffe; end
      7'h63: begin
        case (f3)
          3'd0: e.taken = rs1 == rs2;
          3'd1: e.taken = rs1 != rs2;
          3'd4: e.taken = $signed(rs1) < $signed(rs2);
          3'd5: e.taken = $signed(rs1) >= $signed(rs2);
          3'd6: e.taken = rs1 < rs2;
          3'd7: e.taken = rs1 >= rs2;
          default: e.taken = 0;
        endcase
        if (e.taken) e.tgt = pc + imm;
      end
      7'h73: begin e.taken = 1; e.trap = 1; e.tgt = tv; end
      default: ;
    endcase
    if (e.taken && e.tgt[1]) begin e.trap = 1; e.tgt = tv; end
    return e;
  endfunction
  // Handshakes are evaluated mid-cycle; they complete at the following rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_target", bus.out_target, ptgt);
      end
      if (!bus.in_ready) saw_stall = 1;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_tid", bus.out_tid, e.tid);
          chk("out_taken", bus.out_taken, e.taken);
          chk("out_trap", bus.out_trap, e.trap);
          chk("out_target", bus.out_target, e.tgt);
          chk("out_link", bus.out_link, e.link);
        end
      end
      if (bus.in_valid && bus.in_ready && !bus.flush[bus.in_tid])
        q.push_back(model(bus.opcode, bus.funct3, bus.in_tid, bus.pc, bus.rs1, bus.rs2, bus.imm, bus.trap_vec));
      for (int i = q.size() - 1; i >= 0; i--)
        if (bus.flush[q[i].tid]) q.delete(i);
      pv = bus.out_valid;
      pr = bus.out_ready;
      ptgt = bus.out_target;
    end
  end
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] tid,
                      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    logic acc = 0;
    bus.in_valid = 1;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.in_tid = tid;
    bus.pc = pc;
    bus.rs1 = rs1;
    bus.rs2 = rs2;
    bus.imm = imm;
    do begin
      #3 acc = bus.in_ready;
      @(posedge clk);
      #1 n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    cyc(2);
    chk("drain_empty", q.size(), 0);
  endtask
  logic [6:0] ops[7] = '{7'h6f, 7'h67, 7'h63, 7'h63, 7'h63, 7'h73, 7'h33};
  logic [2:0] f3s[8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
  logic done = 0;
  int n0;
  initial begin
    logic [31:0] r1;
    bus.in_valid = 0;
    bus.in_tid = 0;
    bus.opcode = 0;
    bus.funct3 = 0;
    bus.pc = 0;
    bus.rs1 = 0;
    bus.rs2 = 0;
    bus.imm = 0;
    bus.trap_vec = 32'h0000_8000;
    bus.flush = 0;
    bus.out_ready = 1;
    cyc(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_taken", bus.out_taken, 0);
    chk("rst_out_trap", bus.out_trap, 0);
    chk("rst_out_tid", bus.out_tid, 0);
    chk("rst_out_target", bus.out_target, 0);
    chk("rst_out_link", bus.out_link, 0);
    rst_n = 1;
    cyc(1);
    chk("rst_in_ready", bus.in_ready, 1);
    send(7'h63, 3'd4, 2'd0, 32'h100, 32'hffff_ffff, 32'h1, 32'h20);
    chk("blt_lat1_valid", bus.out_valid, 0);
    cyc(1);
    chk("blt_lat2_valid", bus.out_valid, 1);
    chk("blt_taken", bus.out_taken, 1);
    chk("blt_target", bus.out_target, 32'h120);
    chk("blt_link", bus.out_link, 32'h104);
    send(7'h63, 3'd6, 2'd0, 32'h100, 32'hffff_ffff, 32'h1, 32'h20);
    cyc(1);
    chk("bltu_taken", bus.out_taken, 0);
    chk("bltu_target", bus.out_target, 32'h104);
    send(7'h67, 3'd0, 2'd1, 32'h200, 32'h1001, 32'h0, 32'h3);
    cyc(1);
    chk("jalr_target", bus.out_target, 32'h1004);
    chk("jalr_taken", bus.out_taken, 1);
    chk("jalr_trap", bus.out_trap, 0);
    send(7'h67, 3'd0, 2'd1, 32'h200, 32'h1000, 32'h0, 32'h2);
    cyc(1);
    chk("jalr_mis_trap", bus.out_trap, 1);
    chk("jalr_mis_target", bus.out_target, 32'h8000);
    send(7'h6f, 3'd0, 2'd2, 32'hffff_fffc, 32'h0, 32'h0, 32'h8);
    cyc(1);
    chk("jal_wrap_target", bus.out_target, 32'h4);
    chk("jal_wrap_link", bus.out_link, 32'h0);
    chk("jal_wrap_trap", bus.out_trap, 0);
    send(7'h73, 3'd0, 2'd3, 32'h300, 32'h0, 32'h0, 32'h0);
    send(7'h33, 3'd0, 2'd3, 32'h300, 32'h5, 32'h5, 32'h40);
    send(7'h63, 3'd2, 2'd3, 32'h300, 32'h5, 32'h5, 32'h40);
    send(7'h63, 3'd3, 2'd3, 32'h300, 32'h5, 32'h6, 32'h40);
    send(7'h63, 3'd0, 2'd3, 32'h300, 32'h5, 32'h5, 32'h42);
    wait_drain();
    saw_stall = 0;
    n0 = n_out;
    fork
      for (int i = 0; i < 8; i++) begin
        r1 = $urandom;
        send(7'h63, f3s[i], 2'(i), 32'h1000 + 32'(i * 4), r1, i % 2 == 0 ? r1 : $urandom, 32'h40);
      end
      begin
        cyc(2);
        bus.out_ready = 0;
        cyc(3);
        bus.out_ready = 1;
      end
    join
    wait_drain();
    chk("bp_stall_seen", saw_stall, 1);
    chk("bp_count", n_out - n0, 8);
    bus.out_ready = 0;
    n0 = n_out;
    send(7'h6f, 3'd0, 2'd1, 32'h500, 32'h0, 32'h0, 32'h10);
    send(7'h6f, 3'd0, 2'd2, 32'h600, 32'h0, 32'h0, 32'h10);
    bus.flush = 4'b0100;
    cyc(1);
    bus.flush = 0;
    cyc(1);
    bus.out_ready = 1;
    wait_drain();
    chk("flush_count", n_out - n0, 1);
    n0 = n_out;
    bus.flush = 4'b1000;
    send(7'h6f, 3'd0, 2'd3, 32'h700, 32'h0, 32'h0, 32'h10);
    bus.flush = 0;
    cyc(4);
    chk("flush_in_count", n_out - n0, 0);
    bus.out_ready = 0;
    send(7'h6f, 3'd0, 2'd0, 32'h800, 32'h0, 32'h0, 32'h10);
    send(7'h6f, 3'd0, 2'd1, 32'h900, 32'h0, 32'h0, 32'h10);
    rst_n = 0;
    #1 chk("rst_mid_out_valid", bus.out_valid, 0);
    n0 = n_out;
    cyc(1);
    rst_n = 1;
    bus.out_ready = 1;
    cyc(5);
    chk("rst_no_stale", n_out - n0, 0);
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          r1 = $urandom;
          bus.trap_vec = $urandom;
          send(ops[$urandom_range(0, 6)], f3s[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
               $urandom & 32'hffff_fffc, r1, $urandom_range(0, 3) == 0 ? r1 : $urandom, $urandom);
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 bus.out_ready = $urandom_range(0, 3) != 0;
      end
    join
    bus.out_ready = 1;
    wait_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv_bru.md
RV_BRU -- requirements
Module: rv_bru

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and target width.
REQ-002 Parameter NTHREADS, default 4: number of hardware threads; TW = max(1, clog2(NTHREADS)).
REQ-003 Parameter SKIP_STAGE1, default 0: 1 removes the stage-1 register; latency 1 instead of 2.
REQ-004 clk  in  1  single clock; all state rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-008 in_tid  in  TW  issuing thread.
REQ-009 opcode  in  7  RV32I opcode.
REQ-010 funct3  in  3  branch condition.
REQ-011 pc, rs1, rs2, imm  in  XLEN each  instruction PC, operands, sign-extended immediate.
REQ-012 trap_vec  in  XLEN  trap target, sampled at acceptance.
REQ-013 flush  in  NTHREADS  one-hot-per-bit kill of in-flight results of thread i.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-016 out_tid  out  TW; out_taken  out  1; out_target  out  XLEN; out_link  out  XLEN (pc+4); out_trap  out  1.

Function
REQ-017 Decode: JAL (1101111) taken, target pc+imm; JALR (1100111) taken, target (rs1+imm) with bit0 cleared; BRANCH (1100011) per funct3; SYSTEM (1110011) taken, target trap_vec, out_trap=1; other opcodes not taken, target pc+4.
REQ-018 BRANCH funct3: 0 EQ, 1 NE, 4 LT signed, 5 GE signed, 6 LTU, 7 GEU; 2 and 3 not taken; branch target pc+imm.
REQ-019 Signed compares use two's-complement XLEN-bit interpretation; unsigned compares use zero-extended values.
REQ-020 Misalignment: a taken non-SYSTEM result whose target bit1 is set yields out_trap=1, out_target=trap_vec, out_taken=1.
REQ-021 All adds are modulo 2^XLEN; wrap-around not flagged.
REQ-022 Pipeline: stage-1 register (compare, sums), stage-2 output register; request-to-out_valid latency 2 cycles (1 when SKIP_STAGE1=1).
REQ-023 Each stage holds one entry, valid bit per stage; stage advances when downstream empty or draining same cycle.
REQ-024 in_ready = !s1_valid || s1 advancing (combinational, no dependence on in_valid).
REQ-025 Throughput one result per cycle with out_ready held high.
REQ-026 out_valid held and outputs stable while out_ready low; no result dropped or duplicated.
REQ-027 flush[i] clears any stage entry with tid i in that cycle; flush takes priority over advance; a request with in_tid=i accepted in a cycle where flush[i]=1 is discarded.
REQ-028 Results leave in acceptance order across all threads.

Reset
REQ-029 While rst_n low: stage valid bits 0, out_valid 0, out_taken 0, out_trap 0, out_tid 0, out_target 0, out_link 0.
REQ-030 in_ready 1 on the first edge after rst_n deasserts; reset mid-operation discards all in-flight entries.

Structure
REQ-031 Opcode constants, funct3 condition codes and the stage entry struct in shared package rv_pkg.
REQ-032 One sub-module rv_bru_cond: combinational condition evaluator (funct3, rs1, rs2 -> taken), parametrised by XLEN.

Verification
REQ-033 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> 2 cycles later taken=1, target=0x120, link=0x104; BLTU same operands -> taken=0.
REQ-034 JALR rs1=0x1001, imm=0x3 -> target 0x1004, taken=1, trap=0; rs1=0x1000, imm=0x2 -> trap=1, target=trap_vec.
REQ-035 Back-to-back 8 branches, out_ready low cycles 3-5 -> in_ready drops after two held entries, all 8 results in order, none lost.
REQ-036 Tid 2 in stage 1 and tid 1 in stage 2, flush=0b0100 -> only tid 1 result emitted.
REQ-037 rst_n pulsed low with two entries in flight -> out_valid=0 immediately, no stale result after release.
REQ-038 PC=0xFFFFFFFC JAL imm=8 -> target 0x00000004, link 0x00000000, no trap.
